// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and defaults: entry layout for the prefetch queue
// and a saturating adder for the optional statistics counters.
package fetch_pkg;
    localparam int XLEN = 32;
    localparam int INSTR_W = 32;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [XLEN-1:0]    pc;
    } fetch_entry_t;

    function automatic logic [31:0] sat_add(logic [31:0] a, logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction
endpackage

// File: rtl/fetch_prefetch_queue_if.sv
// Instruction-memory request/response bus between the prefetch stage (master)
// and a single-cycle-latency instruction memory (slave).
interface fetch_prefetch_queue_if #(
    parameter int INSTR_W = fetch_pkg::INSTR_W
);
    import fetch_pkg::*;

    logic               req;
    logic [XLEN-1:0]    addr;
    logic               rvalid;
    logic [INSTR_W-1:0] rdata;

    modport master (output req, output addr, input rvalid, input rdata);
    modport slave  (input req, input addr, output rvalid, output rdata);
endinterface

// File: rtl/prefetch_fifo.sv
// Circular buffer of DEPTH fetch entries with push/pop/clear; head is read
// combinationally so decode sees it in the cycle after the push.
module prefetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type entry_t = fetch_entry_t,
    parameter entry_t RESET_ENTRY = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  entry_t                     push_data,
    input  logic                       pop,
    input  logic                       clear,
    output logic [$clog2(DEPTH):0]     count,
    output entry_t                     head
);
    localparam int AW = $clog2(DEPTH);

    entry_t        mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   cnt;

    // Storage is reset too so the head reads a defined {0, RESET_PC} out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_ENTRY;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    assign count = cnt;
    assign head  = mem[rd_ptr];

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && !pop && !clear && cnt == (AW+1)'(DEPTH)));
endmodule

// File: rtl/fetch_prefetch_queue.sv
// Prefetch stage: PC/epoch/credit logic feeding prefetch_fifo. Define
// PREFETCH_STATS_EN to add saturating fetched/dropped/full counters.
module fetch_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = fetch_pkg::RESET_PC,
    parameter int          INSTR_W  = fetch_pkg::INSTR_W
) (
    input  logic                   clk,
    input  logic                   rst,
    fetch_prefetch_queue_if.master imem,
    input  logic                   PCSrcE,
    input  logic [31:0]            PCTargetE,
    input  logic                   StallD,
    input  logic                   FlushD,
    output logic                   ValidD,
    output logic [INSTR_W-1:0]     InstrD,
    output logic [31:0]            PCD,
    output logic [31:0]            PCPlus4D
`ifdef PREFETCH_STATS_EN
    ,
    output logic [31:0]            stat_fetched,
    output logic [31:0]            stat_dropped,
    output logic [31:0]            stat_full
`endif
);
    import fetch_pkg::*;

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [XLEN-1:0]    pc;
    } entry_t;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] req_pc;
    logic            epoch;
    logic            pending;
    logic            pend_epoch;
    logic [AW:0]     count;
    logic [AW+1:0]   credit;
    logic            inflight;
    logic            req;
    logic            push;
    logic            pop;
    entry_t          push_data;
    entry_t          head;

    // A request only holds a queue slot while its epoch is still current.
    assign inflight = pending && (pend_epoch == epoch);
    assign credit   = {1'b0, count} + (AW+2)'(inflight);
    assign req      = rst && !PCSrcE && (credit < (AW+2)'(DEPTH));
    assign push     = imem.rvalid && inflight && !PCSrcE;
    assign pop      = (count != '0) && (!StallD || FlushD);

    assign imem.req  = req;
    assign imem.addr = pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc         <= RESET_PC;
            req_pc     <= RESET_PC;
            epoch      <= 1'b0;
            pending    <= 1'b0;
            pend_epoch <= 1'b0;
        end else begin
            pending    <= req;
            pend_epoch <= epoch;
            if (req) req_pc <= pc;
            if (PCSrcE) begin
                pc    <= PCTargetE;
                epoch <= ~epoch;
            end else if (req) begin
                pc <= pc + XLEN'(4);
            end
        end
    end

    assign push_data = '{instr: imem.rdata, pc: req_pc};

    prefetch_fifo #(
        .DEPTH      (DEPTH),
        .entry_t    (entry_t),
        .RESET_ENTRY(entry_t'({{INSTR_W{1'b0}}, RESET_PC}))
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(push_data),
        .pop      (pop),
        .clear    (PCSrcE),
        .count    (count),
        .head     (head)
    );

    assign ValidD   = (count != '0) && !FlushD;
    assign InstrD   = head.instr;
    assign PCD      = head.pc;
    assign PCPlus4D = head.pc + XLEN'(4);

`ifdef PREFETCH_STATS_EN
    logic [AW+1:0] drop_n;

    // Stale responses plus every queued entry thrown away by flush or redirect.
    always_comb begin
        drop_n = (AW+2)'(imem.rvalid && !push);
        if (PCSrcE)                      drop_n = drop_n + (AW+2)'(count);
        else if (FlushD && count != '0)  drop_n = drop_n + (AW+2)'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_fetched <= '0;
            stat_dropped <= '0;
            stat_full    <= '0;
        end else begin
            stat_fetched <= sat_add(stat_fetched, 32'(push));
            stat_dropped <= sat_add(stat_dropped, 32'(drop_n));
            stat_full    <= sat_add(stat_full, 32'(count == (AW+1)'(DEPTH)));
        end
    end
`endif
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench: directed vector table, wrap-around instance, random run against a
// queue-based reference model, and a mid-operation reset sequence.
module tb_fetch_prefetch_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        PCSrcE, StallD, FlushD, inject;
    logic [31:0] PCTargetE;
    logic        ValidD, w_valid;
    logic [31:0] InstrD, PCD, PCPlus4D, w_instr, w_pcd, w_pc4;
`ifdef PREFETCH_STATS_EN
    logic [31:0] stat_fetched, stat_dropped, stat_full;
    logic [31:0] w_sf, w_sd, w_sfull;
`endif
    int n_cmp, n_bad;

    always #5 clk = ~clk;

    fetch_prefetch_queue_if #(.INSTR_W(32)) m0 ();
    fetch_prefetch_queue_if #(.INSTR_W(32)) mw ();

    fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0), .INSTR_W(32)) dut (
        .clk(clk), .rst(rst), .imem(m0), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .StallD(StallD), .FlushD(FlushD), .ValidD(ValidD), .InstrD(InstrD),
        .PCD(PCD), .PCPlus4D(PCPlus4D)
`ifdef PREFETCH_STATS_EN
        , .stat_fetched(stat_fetched), .stat_dropped(stat_dropped), .stat_full(stat_full)
`endif
    );

    fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8), .INSTR_W(32)) dut_w (
        .clk(clk), .rst(rst), .imem(mw), .PCSrcE(1'b0), .PCTargetE(32'h0),
        .StallD(1'b0), .FlushD(1'b0), .ValidD(w_valid), .InstrD(w_instr),
        .PCD(w_pcd), .PCPlus4D(w_pc4)
`ifdef PREFETCH_STATS_EN
        , .stat_fetched(w_sf), .stat_dropped(w_sd), .stat_full(w_sfull)
`endif
    );

    function automatic logic [31:0] instr_of(logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    // Single-cycle instruction memories; inject forces a spurious response.
    always @(posedge clk) begin
        m0.rvalid <= m0.req | inject;
        m0.rdata  <= inject ? 32'hDEAD_BEEF : instr_of(m0.addr);
        mw.rvalid <= mw.req;
        mw.rdata  <= instr_of(mw.addr);
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: a plain queue of {instr, pc}, a next-fetch PC and a
    // redirect generation number tagging the single outstanding request.
    typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
    ent_t        mq[$];
    logic [31:0] m_pc, m_lpc;
    int          m_gen, m_lgen;
    bit          m_lreq, m_req;

    task automatic model_reset();
        mq.delete();
        m_pc = 32'h0; m_gen = 0; m_lgen = 0; m_lreq = 0; m_lpc = 0;
    endtask

    task automatic step(bit s, bit f, bit p, logic [31:0] t);
        int occ;
        StallD = s; FlushD = f; PCSrcE = p; PCTargetE = t;
        occ = mq.size() + ((m_lreq && m_lgen == m_gen) ? 1 : 0);
        m_req = !p && (occ < DEPTH);
        @(negedge clk);
        chk("req", m0.req, m_req);
        if (m_req) chk("addr", m0.addr, m_pc);
        chk("valid", ValidD, (mq.size() != 0) && !f);
        if (mq.size() != 0) begin
            chk("pcd", PCD, mq[0].pc);
            chk("instr", InstrD, mq[0].instr);
            chk("pc4", PCPlus4D, mq[0].pc + 32'd4);
        end
        @(posedge clk);
        if (p) begin
            mq.delete(); m_gen++; m_pc = t; m_lreq = 0;
        end else begin
            if (mq.size() != 0 && (!s || f)) void'(mq.pop_front());
            if (m_lreq && m_lgen == m_gen) mq.push_back('{instr_of(m_lpc), m_lpc});
            m_lreq = m_req; m_lgen = m_gen; m_lpc = m_pc;
            if (m_req) m_pc = m_pc + 32'd4;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; PCSrcE = 1'b0; StallD = 1'b0; FlushD = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
    endtask

    typedef struct {
        bit s, f, p; logic [31:0] t;
        bit e_req; logic [31:0] e_addr; bit e_valid; logic [31:0] e_pcd;
    } vec_t;
    vec_t tbl [15];

    initial begin
        logic [31:0] t;
        n_cmp = 0; n_bad = 0; inject = 0;
        rst = 0; PCSrcE = 0; PCTargetE = 0; StallD = 0; FlushD = 0;
        model_reset();

        //          s f p target   req addr        valid pcd
        tbl[0]  = '{0,0,0,32'h0,   1, 32'h0,       0, 32'h0};
        tbl[1]  = '{0,0,0,32'h0,   1, 32'h4,       0, 32'h0};
        tbl[2]  = '{1,0,0,32'h0,   1, 32'h8,       1, 32'h0};
        tbl[3]  = '{1,0,0,32'h0,   1, 32'hC,       1, 32'h0};
        tbl[4]  = '{1,0,0,32'h0,   0, 32'h0,       1, 32'h0};
        tbl[5]  = '{1,0,0,32'h0,   0, 32'h0,       1, 32'h0};
        tbl[6]  = '{0,0,0,32'h0,   0, 32'h0,       1, 32'h0};
        tbl[7]  = '{0,0,0,32'h0,   1, 32'h10,      1, 32'h4};
        tbl[8]  = '{1,1,0,32'h0,   1, 32'h14,      0, 32'h8};
        tbl[9]  = '{1,0,0,32'h0,   1, 32'h18,      1, 32'hC};
        tbl[10] = '{0,0,1,32'h100, 0, 32'h0,       1, 32'hC};
        tbl[11] = '{0,0,0,32'h0,   1, 32'h100,     0, 32'h0};
        tbl[12] = '{0,0,0,32'h0,   1, 32'h104,     0, 32'h0};
        tbl[13] = '{0,0,0,32'h0,   1, 32'h108,     1, 32'h100};
        tbl[14] = '{0,0,0,32'h0,   1, 32'h10C,     1, 32'h104};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", ValidD, 0);
        chk("rst_instr", InstrD, 0);
        chk("rst_pcd", PCD, 32'h0);
        chk("rst_pc4", PCPlus4D, 32'h4);
        chk("rst_req", m0.req, 0);
        chk("rst_w_pcd", w_pcd, 32'hFFFF_FFF8);
        chk("rst_w_pc4", w_pc4, 32'hFFFF_FFFC);
`ifdef PREFETCH_STATS_EN
        chk("rst_stat_fetched", stat_fetched, 0);
`endif
        rst = 1'b1;

        for (int i = 0; i < 15; i++) begin
            StallD = tbl[i].s; FlushD = tbl[i].f; PCSrcE = tbl[i].p; PCTargetE = tbl[i].t;
            @(negedge clk);
            chk($sformatf("tbl%0d_req", i), m0.req, tbl[i].e_req);
            if (tbl[i].e_req) chk($sformatf("tbl%0d_addr", i), m0.addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d_valid", i), ValidD, tbl[i].e_valid);
            if (tbl[i].e_valid) begin
                chk($sformatf("tbl%0d_pcd", i), PCD, tbl[i].e_pcd);
                chk($sformatf("tbl%0d_instr", i), InstrD, instr_of(tbl[i].e_pcd));
                chk($sformatf("tbl%0d_pc4", i), PCPlus4D, tbl[i].e_pcd + 32'd4);
            end
            case (i)
                0: begin chk("wrap_req0", mw.req, 1); chk("wrap_addr0", mw.addr, 32'hFFFF_FFF8); end
                1: chk("wrap_addr1", mw.addr, 32'hFFFF_FFFC);
                2: begin
                    chk("wrap_addr2", mw.addr, 32'h0);
                    chk("wrap_valid2", w_valid, 1);
                    chk("wrap_pcd2", w_pcd, 32'hFFFF_FFF8);
                    chk("wrap_instr2", w_instr, instr_of(32'hFFFF_FFF8));
                end
                3: begin chk("wrap_pcd3", w_pcd, 32'hFFFF_FFFC); chk("wrap_pc4_3", w_pc4, 32'h0); end
                default: ;
            endcase
            @(posedge clk); #1;
        end

        do_reset();
        for (int n = 0; n < 1500; n++) begin
            t = $urandom() & 32'h0000_FFFC;
            step($urandom_range(0, 9) < 4, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 19) == 0, t);
        end

        // Mid-operation reset with three queued entries, then a stray response.
        do_reset();
        step(1, 0, 1, 32'h200);
        repeat (4) step(1, 0, 0, 32'h0);
        @(negedge clk);
        chk("pre_rst_valid", ValidD, 1);
        chk("pre_rst_pcd", PCD, 32'h200);
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_valid", ValidD, 0);
        chk("mid_rst_req", m0.req, 0);
        chk("mid_rst_pcd", PCD, 32'h0);
`ifdef PREFETCH_STATS_EN
        chk("mid_rst_fetched", stat_fetched, 0);
        chk("mid_rst_dropped", stat_dropped, 0);
        chk("mid_rst_full", stat_full, 0);
`endif
        StallD = 0; PCSrcE = 0; FlushD = 0;
        inject = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1; inject = 1'b0;
        model_reset();
        repeat (8) step(0, 0, 0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fetch_prefetch_queue.md
# fetch_prefetch_queue

Instruction prefetch stage sitting directly upstream of the pipeline's decode register, between instruction memory and decode. It generates sequential fetch addresses and issues requests to a single-cycle-latency instruction memory. Returned instructions are buffered with their PC and PC+4 in a small queue. Decode receives them through a valid/stall handshake. A taken branch or jump from execute redirects the PC, empties the queue and discards any in-flight response.

## Interface
Parameters:
- DEPTH, 4: queue entries; power of two, ≥2.
- RESET_PC, 32'h0000_0000: PC after reset.
- INSTR_W, 32: instruction width.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request this cycle.
- imem_addr  out  32  byte address of the request (PC).
- imem_rvalid  in  1  response valid; arrives exactly one cycle after imem_req.
- imem_rdata  in  INSTR_W  instruction returned.
- PCSrcE  in  1  redirect from execute.
- PCTargetE  in  32  redirect target.
- StallD  in  1  decode cannot accept.
- FlushD  in  1  kill the instruction presented to decode.
- ValidD  out  1  InstrD/PCD/PCPlus4D are meaningful.
- InstrD  out  INSTR_W  head instruction.
- PCD  out  32  PC of head instruction.
- PCPlus4D  out  32  PCD+4.

## Operation
- Credit rule: imem_req = rst && !PCSrcE && (count + inflight < DEPTH). inflight is 1 if a request was issued last cycle with the current epoch, else 0.
- On each request, PC <= PC+4, modulo 2^32 (FFFF_FFFC wraps to 0000_0000).
- Each request records its PC and a 1-bit epoch. Every redirect toggles the epoch. A response is written only if its epoch matches the current epoch; otherwise it is dropped silently.
- Queue entry holds {instr, pc}. PCPlus4D = PCD+4, computed combinationally and wrapping.
- Head is presented combinationally: ValidD = (count != 0) && !FlushD.
- Pop when count != 0 && (!StallD || FlushD). FlushD discards the head even while StallD is asserted.
- Redirect (PCSrcE=1): PC <= PCTargetE, count <= 0, epoch toggles, no request that cycle. Fetch from PCTargetE begins the next cycle.
- Simultaneous events:
  - redirect + response + pop: redirect wins and the queue ends empty.
  - push + pop in the same cycle: count is unchanged.
  - full queue: the credit rule guarantees no response arrives. An overflow write is an assertion failure.
- State: PC, epoch, pending, rd/wr pointers (log2 DEPTH bits, natural wrap), count (log2 DEPTH+1 bits).

## Timing
- Reset (rst=0, asynchronous) sets:
  - PC=RESET_PC, count=0, pointers=0, epoch=0, pending=0.
  - ValidD=0, InstrD=0, PCD=RESET_PC, PCPlus4D=RESET_PC+4, imem_req=0.
- First request is in the first cycle after rst deasserts, addr=RESET_PC.
- Latency from request to ValidD: 2 cycles (request cycle N, response N+1, head visible N+2).
- Redirect asserted in cycle N: request to the target in N+1, target instruction valid in N+3.
- Steady state with StallD=0: one instruction per cycle.
- Reset asserted mid-operation: all state clears immediately. A response arriving after reset releases is dropped because pending=0.

## Configuration
- PREFETCH_STATS_EN defined: adds outputs stat_fetched[31:0] (responses accepted), stat_dropped[31:0] (stale responses plus flushed or redirected entries) and stat_full[31:0] (cycles with count==DEPTH). Counters saturate at all-ones and reset to 0.
- Not defined: these ports and their logic are absent, and the functional behaviour is identical.

## Structure
- Shared package fetch_pkg holds:
  - XLEN=32, INSTR_W, RESET_PC default.
  - typedef fetch_entry_t {instr, pc}.
- One sub-module, prefetch_fifo: a parameterised DEPTH x fetch_entry_t circular buffer with push, pop, clear, count and head output. The top holds the PC, epoch and credit logic.

## Test plan
- Reset release, StallD=0, memory returns PC as data → ValidD high from cycle 2; PCD = 0,4,8,… on consecutive cycles; PCPlus4D = PCD+4.
- StallD held high for 10 cycles → count reaches 4, imem_req drops to 0, head stays PCD=0. Release → PCD 4,8,… with no gaps or duplicates.
- PCSrcE pulse, PCTargetE=0x100, while a response for 0x10 is in flight → 0x10 is never presented; next valid PCD=0x100, 3 cycles after the pulse.
- FlushD=1 with StallD=1 at head 0x8 → ValidD=0 that cycle; next head is 0xC.
- RESET_PC=32'hFFFF_FFF8 → fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000; PCPlus4D wraps to 0 for FFFF_FFFC.
- rst asserted with 3 queued entries → ValidD=0 immediately. After release, the first PCD=RESET_PC. With PREFETCH_STATS_EN, stat_fetched=0.
